// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter with locked sequences in front of the data memory
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_rr, w_rr_nxt;
  logic [3:0]  r_lock_cnt, w_lock_cnt_nxt;
  logic        w_gnt0, w_gnt1, w_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr       <= 1'b0;
      r_lock_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr       <= w_rr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_nxt       = r_rr;
    w_lock_cnt_nxt = r_lock_cnt;
    w_lock         = w_gnt0 ? lock0 : lock1;
    if (w_gnt0 || w_gnt1) begin
      if (w_lock && (r_lock_cnt < LOCK_LAST)) begin
        w_state_nxt    = w_gnt0 ? OWN0 : OWN1;
        w_lock_cnt_nxt = r_lock_cnt + 4'd1;
      end else begin
        // Release (voluntary or forced) always hands priority to the other side.
        w_state_nxt    = IDLE;
        w_lock_cnt_nxt = 4'd0;
        w_rr_nxt       = w_gnt0;
      end
    end else if ((r_state == OWN0 && !req0 && !lock0) ||
                 (r_state == OWN1 && !req1 && !lock1)) begin
      w_state_nxt    = IDLE;
      w_lock_cnt_nxt = 4'd0;
    end
  end

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          w_gnt0 = req0 && (!req1 || !r_rr);
          w_gnt1 = req1 && (!req0 || r_rr);
        end
        OWN0:    w_gnt0 = req0;
        OWN1:    w_gnt1 = req1;
        default: ;
      endcase
    end
    mem_memwrite   = 1'b0;
    mem_memread    = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (w_gnt0) begin
      mem_memwrite   = we0;
      mem_memread    = !we0;
      mem_address    = addr0;
      mem_write_data = wdata0;
    end else if (w_gnt1) begin
      mem_memwrite   = we1;
      mem_memread    = !we1;
      mem_address    = addr1;
      mem_write_data = wdata1;
    end
  end

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= w_gnt0 && !we0;
      rvalid1 <= w_gnt1 && !we1;
      if (w_gnt0 && !we0) rdata0 <= mem_read_data;
      if (w_gnt1 && !we1) rdata1 <= mem_read_data;
    end
  end

endmodule
